// File: rtl/pulse_event_scheduler.sv
// Per-channel consecutive-high pulse filters feeding sticky pending bits,
// drained one event at a time by a round-robin valid/ready scheduler.
module pulse_event_scheduler #(
    parameter int NUM_CH     = 4,
    parameter int FILTER_LEN = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         noisy_in,
    input  logic [NUM_CH-1:0]         ch_enable,
    output logic                      evt_valid,
    output logic [$clog2(NUM_CH)-1:0] evt_ch,
    input  logic                      evt_ready,
    output logic [NUM_CH-1:0]         pending,
    output logic [NUM_CH-1:0]         overflow,
    input  logic [NUM_CH-1:0]         ovf_clear
);
    localparam int CW  = $clog2(FILTER_LEN + 1);
    localparam int CHW = $clog2(NUM_CH);
    localparam logic [CW-1:0] CNT_MAX  = CW'(FILTER_LEN);
    localparam logic [CW-1:0] CNT_QUAL = CW'(FILTER_LEN - 1);

    typedef enum logic {EMPTY, OFFER} state_t;

    state_t            state;
    logic [CHW-1:0]    last_grant;
    logic [CHW-1:0]    grant;
    logic              grant_vld;
    logic              free;
    logic [NUM_CH-1:0] qual;
    logic [NUM_CH-1:0] xfer;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_filter
        logic [CW-1:0] cnt;

        // Saturating at FILTER_LEN keeps a long high level from re-qualifying.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt <= '0;
            end else if (!noisy_in[k] || !ch_enable[k]) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
        end

        assign qual[k] = noisy_in[k] && ch_enable[k] && (cnt == CNT_QUAL);
    end

    assign free = (state == EMPTY) || evt_ready;

    // Round-robin search: first pending channel strictly after last_grant, wrapping.
    always_comb begin
        int             idx_int;
        logic [CHW-1:0] idx;
        // NOTE: every combinational output gets a default first so no latch is inferred.
        grant     = '0;
        grant_vld = 1'b0;
        idx_int   = 0;
        idx       = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx_int = (int'(last_grant) + i) % NUM_CH;
            idx     = CHW'(idx_int);
            if (!grant_vld && pending[idx]) begin
                grant     = idx;
                grant_vld = 1'b1;
            end
        end
    end

    always_comb begin
        xfer = '0;
        if (free && grant_vld) begin
            xfer[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= EMPTY;
            evt_valid  <= 1'b0;
            evt_ch     <= '0;
            last_grant <= CHW'(NUM_CH - 1);
            pending    <= '0;
            overflow   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every term reads the pre-edge pending value.
            pending  <= qual | (pending & ~xfer);
            overflow <= (qual & pending & ~xfer) | (overflow & ~ovf_clear);
            if (free) begin
                if (grant_vld) begin
                    state      <= OFFER;
                    evt_valid  <= 1'b1;
                    evt_ch     <= grant;
                    last_grant <= grant;
                end else begin
                    state     <= EMPTY;
                    evt_valid <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_pulse_event_scheduler.sv
// Self-checking bench: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a run-length/queue model.
module tb_pulse_event_scheduler;
    localparam int NUM_CH     = 4;
    localparam int FILTER_LEN = 3;
    localparam int CHW        = $clog2(NUM_CH);

    logic              clk = 1'b0;
    logic              rst;
    logic [NUM_CH-1:0] noisy_in;
    logic [NUM_CH-1:0] ch_enable;
    logic              evt_valid;
    logic [CHW-1:0]    evt_ch;
    logic              evt_ready;
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] overflow;
    logic [NUM_CH-1:0] ovf_clear;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    int m_run [NUM_CH];
    bit [NUM_CH-1:0] m_pend = '0;
    bit [NUM_CH-1:0] m_ovf  = '0;
    bit m_valid = 1'b0;
    int m_ch    = 0;
    int m_last  = NUM_CH - 1;

    pulse_event_scheduler #(.NUM_CH(NUM_CH), .FILTER_LEN(FILTER_LEN)) dut (
        .clk(clk), .rst(rst), .noisy_in(noisy_in), .ch_enable(ch_enable),
        .evt_valid(evt_valid), .evt_ch(evt_ch), .evt_ready(evt_ready),
        .pending(pending), .overflow(overflow), .ovf_clear(ovf_clear)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NUM_CH; k++) m_run[k] = 0;
        m_pend  = '0;
        m_ovf   = '0;
        m_valid = 1'b0;
        m_ch    = 0;
        m_last  = NUM_CH - 1;
    endtask

    // A channel qualifies when its run of enabled high samples reaches exactly FILTER_LEN.
    task automatic model_step();
        bit free;
        int g;
        int c;
        bit [NUM_CH-1:0] q;
        bit [NUM_CH-1:0] x;
        free = !m_valid || evt_ready;
        g = -1;
        if (free) begin
            for (int i = 1; i <= NUM_CH; i++) begin
                c = (m_last + i) % NUM_CH;
                if (g < 0 && m_pend[c]) g = c;
            end
        end
        x = '0;
        if (g >= 0) x[g] = 1'b1;
        for (int k = 0; k < NUM_CH; k++) begin
            if (noisy_in[k] && ch_enable[k]) begin
                if (m_run[k] < 1000) m_run[k]++;
            end else begin
                m_run[k] = 0;
            end
            q[k] = (m_run[k] == FILTER_LEN);
        end
        for (int k = 0; k < NUM_CH; k++) begin
            m_ovf[k]  = (q[k] && m_pend[k] && !x[k]) || (m_ovf[k] && !ovf_clear[k]);
            m_pend[k] = q[k] || (m_pend[k] && !x[k]);
        end
        if (g >= 0) begin
            m_valid = 1'b1;
            m_ch    = g;
            m_last  = g;
        end else if (free) begin
            m_valid = 1'b0;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else     model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("cmp_evt_valid", 32'(evt_valid), 32'(m_valid));
            check("cmp_evt_ch", 32'(evt_ch), 32'(m_ch));
            check("cmp_pending", 32'(pending), 32'(m_pend));
            check("cmp_overflow", 32'(overflow), 32'(m_ovf));
        end
    end

    task automatic cyc(input logic [NUM_CH-1:0] n, input logic [NUM_CH-1:0] e,
                       input logic r, input logic [NUM_CH-1:0] c);
        noisy_in  = n;
        ch_enable = e;
        evt_ready = r;
        ovf_clear = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc('0, '1, 1'b1, '0);
        rst = 1'b0;
    endtask

    task automatic expect_evt(input string name, input logic v, input int ch);
        check({name, "_valid"}, 32'(evt_valid), 32'(v));
        if (v) check({name, "_ch"}, 32'(evt_ch), 32'(ch));
    endtask

    initial begin
        int exp_seq [NUM_CH];
        int pct;
        rst       = 1'b1;
        noisy_in  = '0;
        ch_enable = '1;
        evt_ready = 1'b1;
        ovf_clear = '0;
        @(posedge clk);
        #1;
        check("reset_valid", 32'(evt_valid), 32'd0);
        check("reset_ch", 32'(evt_ch), 32'd0);
        check("reset_pending", 32'(pending), 32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);
        rst = 1'b0;

        // Basic qualification
        cyc(4'b0001, '1, 1'b1, '0);
        cyc(4'b0001, '1, 1'b1, '0);
        cyc(4'b0000, '1, 1'b1, '0);
        check("short_pending", 32'(pending), 32'd0);
        expect_evt("short", 1'b0, 0);
        repeat (3) cyc(4'b0001, '1, 1'b1, '0);
        check("qual_pending", 32'(pending), 32'b0001);
        expect_evt("qual_not_yet", 1'b0, 0);
        cyc(4'b0001, '1, 1'b1, '0);
        expect_evt("qual_evt", 1'b1, 0);
        check("qual_pending_clr", 32'(pending), 32'd0);
        cyc(4'b0001, '1, 1'b1, '0);
        expect_evt("held_no_evt", 1'b0, 0);
        cyc(4'b0000, '1, 1'b1, '0);
        check("held_pending", 32'(pending), 32'd0);

        // Round robin from reset priority
        do_reset();
        repeat (3) cyc(4'b1111, '1, 1'b1, '0);
        check("rr_pending", 32'(pending), 32'b1111);
        for (int i = 0; i < NUM_CH; i++) begin
            cyc('0, '1, 1'b1, '0);
            expect_evt("rr_a", 1'b1, i);
        end
        cyc('0, '1, 1'b1, '0);
        expect_evt("rr_a_done", 1'b0, 0);

        // Round robin after last_grant=1
        do_reset();
        repeat (3) cyc(4'b0010, '1, 1'b1, '0);
        cyc('0, '1, 1'b1, '0);
        expect_evt("rr_prep", 1'b1, 1);
        repeat (3) cyc(4'b1111, '1, 1'b1, '0);
        exp_seq = '{2, 3, 0, 1};
        for (int i = 0; i < NUM_CH; i++) begin
            cyc('0, '1, 1'b1, '0);
            expect_evt("rr_b", 1'b1, exp_seq[i]);
        end
        cyc('0, '1, 1'b1, '0);
        expect_evt("rr_b_done", 1'b0, 0);

        // Backpressure and overflow
        do_reset();
        repeat (3) cyc(4'b0100, '1, 1'b0, '0);
        cyc('0, '1, 1'b0, '0);
        expect_evt("bp_first", 1'b1, 2);
        for (int q = 0; q < 3; q++) begin
            cyc('0, '1, 1'b0, '0);
            expect_evt("bp_stall", 1'b1, 2);
            repeat (3) begin
                cyc(4'b0100, '1, 1'b0, '0);
                expect_evt("bp_stall", 1'b1, 2);
            end
            check("bp_pending", 32'(pending), 32'b0100);
            check("bp_overflow", 32'(overflow), (q == 0) ? 32'd0 : 32'b0100);
        end
        cyc('0, '1, 1'b1, '0);
        expect_evt("bp_second", 1'b1, 2);
        check("bp_pending_drained", 32'(pending), 32'd0);
        cyc('0, '1, 1'b1, '0);
        expect_evt("bp_done", 1'b0, 0);
        check("bp_ovf_sticky", 32'(overflow), 32'b0100);

        // Overflow clear, then clear colliding with a new overflow
        cyc('0, '1, 1'b1, 4'b0100);
        check("ovf_cleared", 32'(overflow), 32'd0);
        repeat (3) cyc(4'b0100, '1, 1'b0, '0);
        cyc('0, '1, 1'b0, '0);
        repeat (3) cyc(4'b0100, '1, 1'b0, '0);
        cyc('0, '1, 1'b0, '0);
        repeat (2) cyc(4'b0100, '1, 1'b0, '0);
        cyc(4'b0100, '1, 1'b0, 4'b0100);
        check("ovf_set_wins", 32'(overflow), 32'b0100);
        cyc('0, '1, 1'b1, 4'b0100);
        check("ovf_cleared2", 32'(overflow), 32'd0);
        repeat (3) cyc('0, '1, 1'b1, '0);
        expect_evt("ovf_drained", 1'b0, 0);

        // Transfer and re-qualify on the same edge
        do_reset();
        repeat (3) cyc(4'b0011, '1, 1'b0, '0);
        cyc('0, '1, 1'b0, '0);
        expect_evt("sim_ch0", 1'b1, 0);
        check("sim_pending1", 32'(pending), 32'b0010);
        repeat (2) cyc(4'b0010, '1, 1'b0, '0);
        cyc(4'b0010, '1, 1'b1, '0);
        expect_evt("sim_ch1_a", 1'b1, 1);
        check("sim_pending_kept", 32'(pending), 32'b0010);
        check("sim_no_ovf", 32'(overflow), 32'd0);
        cyc('0, '1, 1'b1, '0);
        expect_evt("sim_ch1_b", 1'b1, 1);
        cyc('0, '1, 1'b1, '0);
        expect_evt("sim_done", 1'b0, 0);

        // Enable gating and mid-offer reset
        do_reset();
        repeat (5) cyc(4'b1000, 4'b0111, 1'b1, '0);
        check("dis_pending", 32'(pending), 32'd0);
        expect_evt("dis_no_evt", 1'b0, 0);
        repeat (3) cyc(4'b1000, 4'b1111, 1'b0, '0);
        check("en_pending", 32'(pending), 32'b1000);
        cyc('0, '1, 1'b0, '0);
        expect_evt("en_evt", 1'b1, 3);
        rst = 1'b1;
        #1;
        check("rst_valid", 32'(evt_valid), 32'd0);
        check("rst_ch", 32'(evt_ch), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        cyc('0, '1, 1'b1, '0);
        rst = 1'b0;
        repeat (4) begin
            cyc('0, '1, 1'b1, '0);
            expect_evt("post_rst", 1'b0, 0);
        end

        // Randomized traffic, checked by the per-cycle compare process
        pct = 50;
        for (int n = 0; n < 3000; n++) begin
            if (n % 64 == 0) begin
                case ($urandom_range(0, 2))
                    0:       pct = 10;
                    1:       pct = 50;
                    default: pct = 90;
                endcase
            end
            if ($urandom_range(0, 499) == 0) rst = 1'b1;
            cyc(noisy_in ^ NUM_CH'($urandom & $urandom),
                ($urandom_range(0, 7) == 0) ? NUM_CH'($urandom) : '1,
                ($urandom_range(0, 99) < pct),
                ($urandom_range(0, 15) == 0) ? NUM_CH'($urandom) : '0);
            rst = 1'b0;
        end
        repeat (8) cyc('0, '1, 1'b1, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
